// File: rtl/cell_pos_reader_if.sv
// cell_pos_reader_if: cell memory read port plus particle stream bundle
interface cell_pos_reader_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_rden;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_index;
    logic                  out_last;

    modport master (
        output mem_address, mem_rden, mem_wren, out_valid, out_data, out_index, out_last,
        input  mem_q, out_ready
    );

    modport slave (
        input  mem_address, mem_rden, mem_wren, out_valid, out_data, out_index, out_last,
        output mem_q, out_ready
    );
endinterface

// File: rtl/cell_pos_reader.sv
// cell_pos_reader: fetches a cell's particle count, then streams its positions with credit-based backpressure
module cell_pos_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_count_err,
    output logic [ADDR_WIDTH-1:0] o_particle_count,
    cell_pos_reader_if.master     bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_CNT   = 3'd1;
    localparam logic [2:0] S_WAIT_CNT = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;
    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

    logic [2:0]            r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_count, r_addr, r_next, r_tag0, r_tag1;
    logic                  r_err, r_rden;
    logic [1:0]            r_inf;
    logic [1:0]            r_wp, r_rp;
    logic [2:0]            r_fcnt;
    logic [DATA_WIDTH-1:0] r_fd [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fi [FIFO_DEPTH];
    logic                  r_fl [FIFO_DEPTH];

    logic                  w_ret, w_push, w_valid, w_pop, w_over, w_credit, w_drained;
    logic                  w_accept, w_cnt_issue, w_str_issue, w_issue;
    logic [ADDR_WIDTH-1:0] w_raw, w_cnt, w_issue_addr;
    logic [3:0]            w_fill;

    // A read returns in the cycle its 2-stage inflight marker reaches the end; address 0 is the count, never a particle
    assign w_ret        = r_inf[1];
    assign w_push       = w_ret && (r_tag1 != '0);
    assign w_valid      = r_fcnt != 3'd0;
    assign w_pop        = w_valid && bus.out_ready;
    assign w_raw        = bus.mem_q[ADDR_WIDTH-1:0];
    assign w_over       = w_raw > CNT_MAX;
    assign w_cnt        = w_over ? CNT_MAX : w_raw;
    assign w_accept     = (r_state == S_IDLE) && i_start;
    // Every issued-but-unpopped read owns a FIFO slot; a same-cycle pop frees one early so full rate has no bubbles
    assign w_fill       = 4'(r_fcnt) + 4'(r_rden) + 4'(r_inf[0]) + 4'(r_inf[1]);
    assign w_credit     = w_fill < 4'(FIFO_DEPTH) + 4'(w_pop);
    assign w_cnt_issue  = (r_state == S_WAIT_CNT) && w_ret && (w_cnt != '0);
    assign w_str_issue  = (r_state == S_STREAM) && (r_next <= r_count) && w_credit;
    assign w_issue      = w_cnt_issue || w_str_issue;
    assign w_issue_addr = w_cnt_issue ? ADDR_WIDTH'(1) : r_next;
    assign w_drained    = !r_rden && (r_inf == 2'b00) && (r_fcnt == 3'(w_pop));

    assign o_busy           = r_state != S_IDLE;
    assign o_done           = r_state == S_DONE;
    assign o_count_err      = r_err;
    assign o_particle_count = r_count;
    assign bus.mem_address  = r_addr;
    assign bus.mem_rden     = r_rden;
    assign bus.mem_wren     = 1'b0;
    assign bus.out_valid    = w_valid;
    assign bus.out_data     = w_valid ? r_fd[r_rp] : '0;
    assign bus.out_index    = w_valid ? r_fi[r_rp] : '0;
    assign bus.out_last     = w_valid ? r_fl[r_rp] : 1'b0;

    // Run sequencing: count fetch, credit-limited streaming, drain, single-cycle done
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     w_state_nxt = i_start ? S_RD_CNT : S_IDLE;
            S_RD_CNT:   w_state_nxt = S_WAIT_CNT;
            S_WAIT_CNT: w_state_nxt = !w_ret ? S_WAIT_CNT : (w_cnt == '0) ? S_DONE : S_STREAM;
            S_STREAM:   w_state_nxt = (r_next > r_count) ? S_DRAIN : S_STREAM;
            S_DRAIN:    w_state_nxt = w_drained ? S_DONE : S_DRAIN;
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Control, read port, inflight tracking and FIFO bookkeeping; reset drops anything still returning
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_rden  <= 1'b0;
            r_next  <= '0;
            r_inf   <= 2'b00;
            r_tag0  <= '0;
            r_tag1  <= '0;
            r_wp    <= 2'd0;
            r_rp    <= 2'd0;
            r_fcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rden  <= w_accept || w_issue;
            r_addr  <= w_accept ? '0 : w_issue ? w_issue_addr : r_addr;
            r_next  <= w_issue ? w_issue_addr + ADDR_WIDTH'(1) : r_next;
            r_inf   <= {r_inf[0], r_rden};
            r_tag0  <= r_addr;
            r_tag1  <= r_tag0;
            r_count <= (r_state == S_WAIT_CNT && w_ret) ? w_cnt : r_count;
            r_err   <= w_accept ? 1'b0 : (r_state == S_WAIT_CNT && w_ret) ? w_over : r_err;
            r_wp    <= r_wp + 2'(w_push);
            r_rp    <= r_rp + 2'(w_pop);
            r_fcnt  <= r_fcnt + 3'(w_push) - 3'(w_pop);
        end
    end

    // FIFO storage needs no reset: outputs are gated by occupancy
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fd[r_wp] <= bus.mem_q;
            r_fi[r_wp] <= r_tag1;
            r_fl[r_wp] <= r_tag1 == r_count;
        end
    end
endmodule

// File: tb/tb_cell_pos_reader.sv
// tb_cell_pos_reader: table-driven runs plus reset and held-start sequences against a 2-cycle memory model
module tb_cell_pos_reader;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          ready = 1'b0;
    logic          o_busy, o_done, o_count_err;
    logic [AW-1:0] o_particle_count;
    logic [DW-1:0] mem [PN];
    logic [DW-1:0] q1 = '0;
    logic [DW-1:0] q2 = '0;
    int            n_chk = 0;
    int            n_fail = 0;

    cell_pos_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cell_pos_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_start(i_start),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_count_err(o_count_err),
        .o_particle_count(o_particle_count),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory model: data valid two cycles after the read-enable cycle, zero otherwise
    always @(posedge clk) begin
        q1 <= (bus.mem_rden && bus.mem_address < AW'(PN)) ? mem[bus.mem_address] : '0;
        q2 <= q1;
    end
    assign bus.mem_q     = q2;
    assign bus.out_ready = ready;

    typedef struct {
        logic [7:0] raw;
        int         mode;
        int         seed;
        int         exp_n;
        bit         exp_err;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [DW-1:0] pat(input int seed, input int i);
        return {32'(seed * 1000 + i), 32'hA5A50000 ^ 32'(i), ~32'(i * seed + 7)};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] raw, input int seed);
        mem[0] = {88'hC0FFEE123456789ABCDEF0, raw};
        for (int i = 1; i < PN; i++) mem[i] = pat(seed, i);
    endtask

    // One run from start to the IDLE cycle after done; mode 0 = ready always, mode 1 = ready 1 of every 3 cycles
    task automatic run_case(input string nm, input logic [7:0] raw, input int mode, input int seed,
                            input int exp_n, input bit exp_err, input bit hold);
        int c, nxt, issued, rd_cycles, xfers, maxo, done_c;
        bit stall;
        logic [DW+AW:0] held;
        load(raw, seed);
        i_start = 1'b1;
        @(posedge clk);
        c = 0; nxt = 1; issued = 0; rd_cycles = 0; xfers = 0; maxo = 0; done_c = 0; stall = 1'b0; held = '0;
        while (done_c == 0 && c < 3000) begin
            @(negedge clk);
            c++;
            if (!hold) i_start = 1'b0;
            ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            if (c == 1) begin
                chk({nm, ".c1_busy"}, 128'(o_busy), 128'(1));
                chk({nm, ".c1_rden_addr"}, {bus.mem_rden, bus.mem_address}, {1'b1, 8'd0});
                chk({nm, ".c1_err_clear"}, 128'(o_count_err), 128'(0));
            end
            if (bus.mem_rden) rd_cycles++;
            if (bus.mem_rden && bus.mem_address != '0) issued++;
            if (issued - xfers > maxo) maxo = issued - xfers;
            if (stall) chk({nm, ".stall_hold"}, {bus.out_valid, bus.out_data, bus.out_index, bus.out_last}, {1'b1, held});
            stall = bus.out_valid && !ready;
            held = {bus.out_data, bus.out_index, bus.out_last};
            if (bus.out_valid && ready) begin
                chk({nm, ".index"}, 128'(bus.out_index), 128'(nxt));
                chk({nm, ".data"}, 128'(bus.out_data), 128'(pat(seed, nxt)));
                chk({nm, ".last"}, 128'(bus.out_last), 128'(nxt == exp_n));
                if (mode == 0) chk({nm, ".xfer_cycle"}, 128'(c), 128'(6 + nxt));
                nxt++;
                xfers++;
            end
            if (o_done) done_c = c;
        end
        if (done_c == 0) begin
            chk({nm, ".done_timeout"}, 128'(0), 128'(1));
        end else begin
            chk({nm, ".xfers"}, 128'(xfers), 128'(exp_n));
            chk({nm, ".reads"}, 128'(rd_cycles), 128'(exp_n + 1));
            chk({nm, ".pcount"}, 128'(o_particle_count), 128'(exp_n));
            chk({nm, ".count_err"}, 128'(o_count_err), 128'(exp_err));
            chk({nm, ".credit_bound"}, 128'(maxo <= 4), 128'(1));
            if (mode == 1 && exp_n >= 8) chk({nm, ".credit_reached"}, 128'(maxo), 128'(4));
            if (mode == 0) chk({nm, ".done_cycle"}, 128'(done_c), 128'(exp_n == 0 ? 4 : 7 + exp_n));
            @(negedge clk);
            chk({nm, ".idle_after_done"}, {o_busy, o_done, bus.out_valid}, 128'(0));
            chk({nm, ".err_sticky"}, 128'(o_count_err), 128'(exp_err));
        end
    endtask

    // Watchdog so the bench always terminates
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'd0,   0, 1, 0,   1'b0};
        vecs[1] = '{8'd3,   0, 2, 3,   1'b0};
        vecs[2] = '{8'd20,  1, 3, 20,  1'b0};
        vecs[3] = '{8'd255, 0, 4, 219, 1'b1};
        vecs[4] = '{8'd1,   0, 6, 1,   1'b0};
        vecs[5] = '{8'd219, 1, 7, 219, 1'b0};
        vecs[6] = '{8'd220, 0, 8, 219, 1'b1};

        repeat (2) @(negedge clk);
        chk("reset_outputs", {o_busy, o_done, o_count_err, o_particle_count, bus.mem_address, bus.mem_rden,
                              bus.mem_wren, bus.out_valid, bus.out_data, bus.out_index, bus.out_last}, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++)
            run_case($sformatf("vec%0d", v), vecs[v].raw, vecs[v].mode, vecs[v].seed, vecs[v].exp_n, vecs[v].exp_err, 1'b0);

        // Reset while the fifth particle is presented and later reads are in flight
        load(8'd10, 5);
        ready = 1'b1;
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_pre_index", {bus.out_valid, bus.out_index}, {1'b1, 8'd5});
        chk("rst_pre_rden", 128'(bus.mem_rden), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {o_busy, o_done, o_count_err, o_particle_count, bus.mem_address, bus.mem_rden,
                                bus.mem_wren, bus.out_valid, bus.out_data, bus.out_index, bus.out_last}, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_quiet", {bus.out_valid, o_busy, bus.mem_rden}, 128'(0));
        end
        run_case("post_reset", 8'd10, 0, 9, 10, 1'b0, 1'b0);

        // Start held high through done: second run starts from the first IDLE cycle with count_err cleared
        run_case("hold_a", 8'd230, 0, 11, 219, 1'b1, 1'b1);
        run_case("hold_b", 8'd2, 0, 12, 2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
